// File: rtl/noise_acq_pkg.sv
// ============================================================================
// noise_acq_pkg
// Shared types and helpers for the noise acquisition block: FSM state
// encoding, minimum divider ratio and the ADC-to-readback extension helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package noise_acq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Smallest usable sample period; smaller requests are raised to this.
  localparam int unsigned MIN_DIV = 2;

  // Extend a w-bit sample to 64 bits; sgn selects sign- vs zero-extension.
  function automatic logic [63:0] extend_sample(input logic [63:0] s,
                                                input int unsigned w,
                                                input logic sgn);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < w) r[6'(i)] = s[6'(i)];
      else       r[6'(i)] = sgn & s[6'(w - 1)];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/noise_rd_sync.sv
// ============================================================================
// noise_rd_sync
// Two-flop synchroniser for the asynchronous DSP read strobe followed by an
// edge register; rise_o is a one-cycle pulse per rising strobe edge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module noise_rd_sync (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic strobe_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic edge_q;

  // Metastability chain plus one delayed copy for edge detection.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= strobe_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~edge_q;

endmodule

`default_nettype wire

// File: rtl/noise_acq_gen2.sv
// ============================================================================
// noise_acq_gen2
// Single-clock noise acquisition: programmable ADC sample clock generated by
// clock enable, capture of a programmed number of samples into an internal
// buffer, and a synchronised strobe-driven readback port.
// Optional macro: NOISE_SIGNEXT_EN - sign-extend readback words instead of
// zero-extending them.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module noise_acq_gen2
  import noise_acq_pkg::*;
#(
  parameter int ADC_W  = 12,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 12,
  parameter int DIV_W  = 10
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DIV_W-1:0]  divnum,
  input  logic [ADDR_W:0]   acqnum,
  input  logic              en,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              acq_clk_o,
  output logic              busy,
  output logic              done,
  input  logic              rd_strobe,
  input  logic              rd_en,
  input  logic              rd_clr,
  output logic [OUT_W-1:0]  dataout,
  output logic              rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef NOISE_SIGNEXT_EN
  localparam logic SIGNEXT = 1'b1;
`else
  localparam logic SIGNEXT = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_r_q, div_r_d;
  logic [ADDR_W:0]     num_r_q, num_r_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     sample_cnt_q, sample_cnt_d;
  logic                acq_clk_q, acq_clk_d;
  logic                strobe;
  logic                we;

  logic [ADC_W-1:0]    mem [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [OUT_W-1:0]    dataout_q;
  logic                rd_valid_q;
  logic                rd_rise;
  logic                rd_fire;

  // Acquisition state, divider and write pointer registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_r_q      <= DIV_W'(MIN_DIV);
      num_r_q      <= '0;
      div_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      sample_cnt_q <= '0;
      acq_clk_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_r_q      <= div_r_d;
      num_r_q      <= num_r_d;
      div_cnt_q    <= div_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      sample_cnt_q <= sample_cnt_d;
      acq_clk_q    <= acq_clk_d;
    end
  end

  // Next-state: load restarts from any state; otherwise divide and capture.
  always_comb begin
    state_d      = state_q;
    div_r_d      = div_r_q;
    num_r_d      = num_r_q;
    div_cnt_d    = div_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    sample_cnt_d = sample_cnt_q;
    strobe       = (state_q == ACQ) && (div_cnt_q == div_r_q - 1'b1);
    // A load in the same cycle as a strobe discards that sample.
    we           = strobe && en && !load;

    if (load) begin
      div_r_d      = (divnum < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divnum;
      num_r_d      = (acqnum > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : acqnum;
      wr_ptr_d     = '0;
      sample_cnt_d = '0;
      div_cnt_d    = '0;
      state_d      = (num_r_d != '0) ? ACQ : DONE;
    end else if (state_q == ACQ) begin
      div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;
      if (we) begin
        wr_ptr_d     = wr_ptr_q + 1'b1;
        sample_cnt_d = sample_cnt_q + 1'b1;
        if (sample_cnt_q + 1'b1 == num_r_q) begin
          state_d   = DONE;
          div_cnt_d = '0;
        end
      end
    end else begin
      div_cnt_d = '0;
    end

    // Registered from next-state values so the clock lines up with busy.
    acq_clk_d = (state_d == ACQ) && (div_cnt_d >= (div_r_d >> 1));
  end

  assign acq_clk_o = acq_clk_q;
  assign busy      = (state_q == ACQ);
  assign done      = (state_q == DONE);

  // Sample buffer write port; no reset on the array.
  always_ff @(posedge clk_sys) begin
    if (we) mem[wr_ptr_q] <= adc_data;
  end

  noise_rd_sync u_rd_sync (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .strobe_i (rd_strobe),
    .rise_o   (rd_rise)
  );

  assign rd_fire = rd_rise && rd_en && !rd_clr;

  // Readback port: clear wins over a coincident edge; reads see old data.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      dataout_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_clr) begin
        rd_ptr_q <= '0;
      end else if (rd_fire) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        dataout_q <= OUT_W'(extend_sample(64'(mem[rd_ptr_q]), ADC_W, SIGNEXT));
      end
    end
  end

  assign dataout  = dataout_q;
  assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_noise_acq_gen2.sv
// ============================================================================
// tb_noise_acq_gen2
// Randomised self-checking bench for noise_acq_gen2 with a cycle-count
// reference model and a readback scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noise_acq_gen2;

  localparam int ADC_W  = 12;
  localparam int OUT_W  = 16;
  localparam int ADDR_W = 5;
  localparam int DIV_W  = 10;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk_sys = 1'b0;
  logic              rst_n   = 1'b0;
  logic              load    = 1'b0;
  logic [DIV_W-1:0]  divnum  = '0;
  logic [ADDR_W:0]   acqnum  = '0;
  logic              en      = 1'b0;
  logic [ADC_W-1:0]  adc_data = '0;
  logic              acq_clk_o, busy, done;
  logic              rd_strobe = 1'b0;
  logic              rd_en     = 1'b0;
  logic              rd_clr    = 1'b0;
  logic [OUT_W-1:0]  dataout;
  logic              rd_valid;

  int n_checks = 0;
  int n_err    = 0;

  logic [ADC_W-1:0] model_mem [DEPTH];
  int               model_rd_ptr = 0;
  logic [OUT_W-1:0] exp_q [$];

  always #5 clk_sys = ~clk_sys;

  noise_acq_gen2 #(
    .ADC_W (ADC_W), .OUT_W (OUT_W), .ADDR_W (ADDR_W), .DIV_W (DIV_W)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .load      (load),
    .divnum    (divnum),
    .acqnum    (acqnum),
    .en        (en),
    .adc_data  (adc_data),
    .acq_clk_o (acq_clk_o),
    .busy      (busy),
    .done      (done),
    .rd_strobe (rd_strobe),
    .rd_en     (rd_en),
    .rd_clr    (rd_clr),
    .dataout   (dataout),
    .rd_valid  (rd_valid)
  );

  function automatic logic [OUT_W-1:0] ext(input logic [ADC_W-1:0] s);
`ifdef NOISE_SIGNEXT_EN
    return {{(OUT_W-ADC_W){s[ADC_W-1]}}, s};
`else
    return {{(OUT_W-ADC_W){1'b0}}, s};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest expectation.
  always @(negedge clk_sys) begin
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_rd_valid: got dataout 0x%0h, expected no read at %0t",
                 dataout, $time);
      end else begin
        chk("readback", 32'(dataout), 32'(exp_q.pop_front()));
      end
    end
  end

  // Load and run one acquisition, checking busy/done/acq_clk every cycle.
  // mode: 0 random data, 1 ramp (value = samples stored so far), 2 const 0x800.
  // abort_at > 0 returns while still acquiring, after that many samples.
  task automatic run_acq(input int div, input int num, input int mode,
                         input int pause_pct, input int abort_at);
    int eff_div, eff_num, cnt, ptr, c;
    bit exp_clk;
    eff_div = (div < 2) ? 2 : div;
    eff_num = (num > DEPTH) ? DEPTH : num;
    load   = 1'b1;
    divnum = DIV_W'(div);
    acqnum = (ADDR_W+1)'(num);
    adc_data = ADC_W'($urandom);
    @(posedge clk_sys); #1;
    load = 1'b0;
    cnt = 0;
    ptr = 0;
    if (eff_num == 0) begin
      @(negedge clk_sys);
      chk("zero_cnt_done", 32'(done), 32'd1);
      chk("zero_cnt_busy", 32'(busy), 32'd0);
      @(posedge clk_sys); #1;
      return;
    end
    c = 1;
    while (1) begin
      case (mode)
        1:       adc_data = ADC_W'(cnt);
        2:       adc_data = 12'h800;
        default: adc_data = ADC_W'($urandom);
      endcase
      en = (pause_pct > 0) ? ($urandom_range(0, 99) >= pause_pct) : 1'b1;
      @(negedge clk_sys);
      exp_clk = (((c - 1) % eff_div) >= (eff_div / 2));
      if (busy !== 1'b1 || done !== 1'b0) chk("acq_busy_done", {30'd0, busy, done}, 32'b10);
      if (acq_clk_o !== exp_clk) chk("acq_clk", 32'(acq_clk_o), 32'(exp_clk));
      if ((c % eff_div) == 0 && en) begin
        model_mem[ptr] = adc_data;
        ptr++;
        cnt++;
      end
      @(posedge clk_sys); #1;
      if (cnt == eff_num) break;
      if (abort_at > 0 && cnt == abort_at) return;
      c++;
      if (c > 20000) begin
        chk("acq_cycle_budget", 32'(c), 32'd20000);
        return;
      end
    end
    @(negedge clk_sys);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'(done), 32'd1);
    chk("end_acq_clk", 32'(acq_clk_o), 32'd0);
    chk("acq_cycles", 32'(c), 32'(eff_num * eff_div + (c - eff_num * eff_div) * 32'(pause_pct > 0)));
    @(posedge clk_sys); #1;
  endtask

  // One full strobe pulse (3 high, 3 low); clr held across the detect window.
  task automatic read_word(input bit en_v, input bit clr_v);
    rd_en     = en_v;
    rd_clr    = clr_v;
    rd_strobe = 1'b1;
    if (clr_v) begin
      model_rd_ptr = 0;
    end else if (en_v) begin
      exp_q.push_back(ext(model_mem[model_rd_ptr]));
      model_rd_ptr = (model_rd_ptr + 1) % DEPTH;
    end
    repeat (3) begin @(posedge clk_sys); #1; end
    rd_clr    = 1'b0;
    rd_strobe = 1'b0;
    repeat (3) begin @(posedge clk_sys); #1; end
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) read_word(1'b1, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk_sys);
    #1 rst_n = 1'b1;
    @(negedge clk_sys);
    chk("rst_acq_clk", 32'(acq_clk_o), 32'd0);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_done",    32'(done),      32'd0);
    chk("rst_dataout", 32'(dataout),   32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk_sys); #1;

    // Basic ramp capture and readback.
    run_acq(4, 8, 1, 0, 0);
    read_n(8);

    // Paused capture, then clear coincident with an edge before reading.
    run_acq(4, 5, 0, 30, 0);
    read_word(1'b1, 1'b1);
    read_n(5);

    // Divider clamp.
    run_acq(0, 6, 0, 0, 0);
    read_word(1'b0, 1'b1);
    read_n(6);

    // Restart mid-acquisition.
    run_acq(3, 10, 0, 0, 3);
    run_acq(5, 4, 0, 0, 0);
    read_word(1'b0, 1'b1);
    read_n(4);

    // Zero sample count.
    run_acq(4, 0, 0, 0, 0);

    // Depth clamp plus pointer wrap on readback.
    run_acq(2, DEPTH + 5, 0, 0, 0);
    read_word(1'b0, 1'b1);
    read_n(DEPTH + 3);

    // Extension of a negative-looking sample.
    run_acq(2, 2, 2, 0, 0);
    read_word(1'b0, 1'b1);
    read_n(2);

    // Edge with rd_en low must not read or advance.
    read_word(1'b0, 1'b0);
    read_n(1);

    repeat (8) begin @(posedge clk_sys); #1; end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
